div4_seq: RTL and testbench



---
 rtl/div4_seq.sv | 115 +++++++++++
 tb/tb_div4_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/div4_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with a one-cycle divide-by-zero shortcut.
module div4_seq #(
  parameter int WIDTH = 4
) (
  input  logic             CLK_in,
  input  logic             RST_in,
  input  logic             START_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] Q_out,
  output logic [WIDTH-1:0] R_out,
  output logic             BUSY_out,
  output logic             DONE_out,
  output logic             DZ_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DZERO} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] w, w_n;
  logic [WIDTH:0]   p, p_n;
  logic [WIDTH-1:0] d, d_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] q_n, r_n;
  logic             done_n, dz_n;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] w_sh;
  logic [WIDTH:0]   diff;

  // {P,W} shifted left one place; diff's MSB is the borrow of the trial subtract.
  assign p_sh = {p[WIDTH-1:0], w[WIDTH-1]};
  assign w_sh = {w[WIDTH-2:0], 1'b0};
  assign diff = p_sh - {1'b0, d};

  assign BUSY_out = (state != IDLE);

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      state    <= IDLE;
      w        <= '0;
      p        <= '0;
      d        <= '0;
      cnt      <= '0;
      Q_out    <= '0;
      R_out    <= '0;
      DONE_out <= 1'b0;
      DZ_out   <= 1'b0;
    end else begin
      state    <= state_n;
      w        <= w_n;
      p        <= p_n;
      d        <= d_n;
      cnt      <= cnt_n;
      Q_out    <= q_n;
      R_out    <= r_n;
      DONE_out <= done_n;
      DZ_out   <= dz_n;
    end
  end

  always_comb begin
    state_n = state;
    w_n     = w;
    p_n     = p;
    d_n     = d;
    cnt_n   = cnt;
    q_n     = Q_out;
    r_n     = R_out;
    dz_n    = DZ_out;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (START_in) begin
          w_n     = A_in;
          p_n     = '0;
          d_n     = B_in;
          cnt_n   = '0;
          state_n = (B_in == '0) ? DZERO : RUN;
        end
      end

      RUN: begin
        // Keep the difference only when the subtract did not borrow (restoring step).
        p_n   = diff[WIDTH] ? p_sh : diff;
        w_n   = {w_sh[WIDTH-1:1], ~diff[WIDTH]};
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          q_n     = w_n;
          r_n     = p_n[WIDTH-1:0];
          dz_n    = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end

      DZERO: begin
        q_n     = '1;
        r_n     = w;
        dz_n    = 1'b1;
        done_n  = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div4_seq.sv
// Directed self-checking bench for div4_seq: handshake timing, ignored START,
// divide-by-zero, mid-run reset and a back-to-back sweep of all operand pairs.
module tb_div4_seq;

  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic [3:0] q, r;
  logic       busy, done, dz;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  div4_seq #(.WIDTH(WIDTH)) dut (
    .CLK_in  (clk),
    .RST_in  (rst),
    .START_in(start),
    .A_in    (a),
    .B_in    (b),
    .Q_out   (q),
    .R_out   (r),
    .BUSY_out(busy),
    .DONE_out(done),
    .DZ_out  (dz)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] av, input logic [3:0] bv);
    start = s;
    a     = av;
    b     = bv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkQuiet(input string tag, input logic [3:0] eq, input logic [3:0] er,
                            input logic edz);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " q"},    32'(q),    32'(eq));
    checkOutput({tag, " r"},    32'(r),    32'(er));
    checkOutput({tag, " dz"},   32'(dz),   32'(edz));
  endtask

  // Issues a divide in the current (idle or DONE) cycle and ends in its DONE cycle.
  task automatic runDivide(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] eq,
                           input logic [3:0] er, input logic edz);
    int    lat;
    string tag;
    tag = $sformatf("div %0d/%0d", av, bv);
    lat = (bv == 4'd0) ? 1 : WIDTH;
    applyStimulus(1'b1, av, bv);
    step();
    applyStimulus(1'b0, 4'($urandom), 4'($urandom));
    for (int i = 0; i < lat; i++) begin
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " early done"}, 32'(done), 32'd0);
      step();
    end
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " busy end"}, 32'(busy), 32'd0);
    checkOutput({tag, " q"},  32'(q),  32'(eq));
    checkOutput({tag, " r"},  32'(r),  32'(er));
    checkOutput({tag, " dz"}, 32'(dz), 32'(edz));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0);
    step();
    step();
    checkQuiet("reset", 4'd0, 4'd0, 1'b0);
    rst = 1'b0;
    step();
    checkQuiet("idle hold", 4'd0, 4'd0, 1'b0);

    runDivide(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
    step();
    checkQuiet("after 13/4", 4'd3, 4'd1, 1'b0);

    runDivide(4'd4, 4'd7, 4'd0, 4'd4, 1'b0);
    step();
    runDivide(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    step();
    runDivide(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    step();

    runDivide(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
    step();
    checkQuiet("after 9/0", 4'd15, 4'd9, 1'b1);
    runDivide(4'd6, 4'd3, 4'd2, 4'd0, 1'b0);
    step();

    // START pulsed mid-divide must not disturb the running 12/5.
    applyStimulus(1'b1, 4'd12, 4'd5);
    step();
    applyStimulus(1'b0, 4'd0, 4'd0);
    step();
    checkOutput("ign busy1", 32'(busy), 32'd1);
    applyStimulus(1'b1, 4'd1, 4'd1);
    step();
    checkOutput("ign busy2", 32'(busy), 32'd1);
    checkOutput("ign done2", 32'(done), 32'd0);
    applyStimulus(1'b0, 4'd0, 4'd0);
    step();
    checkOutput("ign busy3", 32'(busy), 32'd1);
    step();
    checkOutput("ign done", 32'(done), 32'd1);
    checkOutput("ign q",    32'(q),    32'd2);
    checkOutput("ign r",    32'(r),    32'd2);
    checkOutput("ign dz",   32'(dz),   32'd0);
    runDivide(4'd7, 4'd2, 4'd3, 4'd1, 1'b0);
    step();
    checkQuiet("after 7/2", 4'd3, 4'd1, 1'b0);

    // Reset during a divide aborts it with no DONE.
    applyStimulus(1'b1, 4'd14, 4'd3);
    step();
    applyStimulus(1'b0, 4'd0, 4'd0);
    step();
    rst = 1'b1;
    step();
    checkQuiet("abort", 4'd0, 4'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("abort no done", 32'(done), 32'd0);
      checkOutput("abort no busy", 32'(busy), 32'd0);
    end

    rst = 1'b1;
    applyStimulus(1'b1, 4'd5, 4'd1);
    step();
    checkOutput("rst prio busy", 32'(busy), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0);
    step();
    checkQuiet("rst prio", 4'd0, 4'd0, 1'b0);

    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        if (bi == 0)
          runDivide(4'(ai), 4'(bi), 4'd15, 4'(ai), 1'b1);
        else
          runDivide(4'(ai), 4'(bi), 4'(ai / bi), 4'(ai % bi), 1'b0);
      end
    end
    step();
    checkOutput("sweep end done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
